// File: rtl/acorn_phase_if.sv
// Handshake/bus bundle for the ACORN-128 phase sequencer.
// ACORN_PHASE_ABORT_EN adds the abort/aborted pair.
interface acorn_phase_if #(
  parameter int AD_BITS = 128,
  parameter int PT_BITS = 128,
  parameter int LW      = $clog2(((AD_BITS > PT_BITS) ? AD_BITS : PT_BITS) + 1)
);
  logic               start;
  logic [127:0]       key_in;
  logic [127:0]       iv_in;
  logic [AD_BITS-1:0] ad_in;
  logic [LW-1:0]      ad_len;
  logic [PT_BITS-1:0] pt_in;
  logic [LW-1:0]      pt_len;
  logic               upd_en;
  logic               m_bit;
  logic               ca;
  logic               cb;
  logic               enc_vld;
  logic [LW-1:0]      enc_idx;
  logic               tag_vld;
  logic               busy;
  logic               done;
`ifdef ACORN_PHASE_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  modport master (
`ifdef ACORN_PHASE_ABORT_EN
    output abort, input aborted,
`endif
    output start, key_in, iv_in, ad_in, ad_len, pt_in, pt_len,
    input  upd_en, m_bit, ca, cb, enc_vld, enc_idx, tag_vld, busy, done
  );

  modport slave (
`ifdef ACORN_PHASE_ABORT_EN
    input abort, output aborted,
`endif
    input  start, key_in, iv_in, ad_in, ad_len, pt_in, pt_len,
    output upd_en, m_bit, ca, cb, enc_vld, enc_idx, tag_vld, busy, done
  );
endinterface

// File: rtl/acorn_phase_ctrl.sv
// ACORN-128 phase sequencer: INIT/AD/ENC/FINAL step strobes, message bit, ca/cb.
// Optional ACORN_PHASE_ABORT_EN adds a run abort input and aborted pulse.
module acorn_phase_ctrl #(
  parameter int AD_BITS = 128,
  parameter int PT_BITS = 128,
  parameter int LW      = $clog2(((AD_BITS > PT_BITS) ? AD_BITS : PT_BITS) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  acorn_phase_if.slave  bus
);
  localparam int CW  = 11;
  localparam int ADW = $clog2(AD_BITS);
  localparam int PTW = $clog2(PT_BITS);

  typedef enum logic [2:0] {IDLE, INIT, AD, ENC, FIN, DONE} state_t;

  state_t             state, ns;
  logic [CW-1:0]      cnt, nc;
  logic [127:0]       key_q, iv_q, k_s, iv_s;
  logic [AD_BITS-1:0] ad_q, ad_s;
  logic [PT_BITS-1:0] pt_q, pt_s;
  logic [CW-1:0]      adl_q, ptl_q, adl_s, ptl_s;
  logic               go, kill;
  logic               upd_d, m_d, ca_d, cb_d, ev_d, tv_d, busy_d, done_d;
  logic [LW-1:0]      idx_d;

  function automatic logic [CW-1:0] clamp(input logic [LW-1:0] len, input int unsigned cap);
    if (32'(len) > cap) return CW'(cap);
    return CW'(len);
  endfunction

  // Next state/step; outputs below are computed for the step being entered
  // so that the registered strobes line up with the state they describe.
  always_comb begin
    ns   = state;
    nc   = cnt + 11'd1;
    go   = (state == IDLE) && bus.start;
    kill = 1'b0;
`ifdef ACORN_PHASE_ABORT_EN
    if (bus.abort) begin
      go   = 1'b0;
      kill = (state == INIT) || (state == AD) || (state == ENC) || (state == FIN);
    end
`endif
    case (state)
      IDLE: begin nc = '0; if (go) ns = INIT; end
      INIT: if (cnt == 11'd1791)           begin ns = AD;   nc = '0; end
      AD:   if (cnt == adl_q + 11'd255)    begin ns = ENC;  nc = '0; end
      ENC:  if (cnt == ptl_q + 11'd255)    begin ns = FIN;  nc = '0; end
      FIN:  if (cnt == 11'd767)            begin ns = DONE; nc = '0; end
      DONE: begin ns = IDLE; nc = '0; end
      default: begin ns = IDLE; nc = '0; end
    endcase
    if (kill) begin
      ns = IDLE;
      nc = '0;
    end
  end

  assign k_s   = go ? bus.key_in : key_q;
  assign iv_s  = go ? bus.iv_in  : iv_q;
  assign ad_s  = go ? bus.ad_in  : ad_q;
  assign pt_s  = go ? bus.pt_in  : pt_q;
  assign adl_s = go ? clamp(bus.ad_len, AD_BITS) : adl_q;
  assign ptl_s = go ? clamp(bus.pt_len, PT_BITS) : ptl_q;

  always_comb begin
    upd_d = 1'b0; m_d = 1'b0; ca_d = 1'b0; cb_d = 1'b0; ev_d = 1'b0;
    idx_d = '0;   tv_d = 1'b0; busy_d = 1'b0; done_d = 1'b0;
    case (ns)
      INIT: begin
        upd_d = 1'b1; busy_d = 1'b1; ca_d = 1'b1; cb_d = 1'b1;
        if (nc < 11'd128)       m_d = k_s[nc[6:0]];
        else if (nc < 11'd256)  m_d = iv_s[nc[6:0]];
        else if (nc == 11'd256) m_d = ~k_s[0];
        else                    m_d = k_s[nc[6:0]];
      end
      AD: begin
        upd_d = 1'b1; busy_d = 1'b1; cb_d = 1'b1;
        m_d   = (nc < adl_s) ? ad_s[nc[ADW-1:0]] : (nc == adl_s);
        ca_d  = (nc < adl_s + 11'd128);
      end
      ENC: begin
        upd_d = 1'b1; busy_d = 1'b1;
        m_d   = (nc < ptl_s) ? pt_s[nc[PTW-1:0]] : (nc == ptl_s);
        ca_d  = (nc < ptl_s + 11'd128);
        ev_d  = (nc < ptl_s);
        idx_d = ev_d ? nc[LW-1:0] : '0;
      end
      FIN: begin
        upd_d = 1'b1; busy_d = 1'b1; ca_d = 1'b1; cb_d = 1'b1;
        tv_d  = (nc >= 11'd640);
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;   cnt <= '0;
      key_q <= '0;     iv_q <= '0;  ad_q <= '0;  pt_q <= '0;
      adl_q <= '0;     ptl_q <= '0;
      bus.upd_en <= 1'b0; bus.m_bit <= 1'b0; bus.ca <= 1'b0; bus.cb <= 1'b0;
      bus.enc_vld <= 1'b0; bus.enc_idx <= '0; bus.tag_vld <= 1'b0;
      bus.busy <= 1'b0; bus.done <= 1'b0;
`ifdef ACORN_PHASE_ABORT_EN
      bus.aborted <= 1'b0;
`endif
    end else begin
      state <= ns;
      cnt   <= nc;
      if (go) begin
        key_q <= k_s;   iv_q <= iv_s;  ad_q <= ad_s;  pt_q <= pt_s;
        adl_q <= adl_s; ptl_q <= ptl_s;
      end
      bus.upd_en  <= upd_d;  bus.m_bit   <= m_d;   bus.ca   <= ca_d;
      bus.cb      <= cb_d;   bus.enc_vld <= ev_d;  bus.enc_idx <= idx_d;
      bus.tag_vld <= tv_d;   bus.busy    <= busy_d; bus.done <= done_d;
`ifdef ACORN_PHASE_ABORT_EN
      bus.aborted <= kill;
`endif
    end
  end
endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// Bench for acorn_phase_ctrl: per-run expected step stream in a scoreboard queue,
// run table plus hand sequences for restart/reset (and abort when enabled).
module tb_acorn_phase_ctrl;
  localparam int AD_BITS = 128;
  localparam int PT_BITS = 128;
  localparam int LW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acorn_phase_if #(.AD_BITS(AD_BITS), .PT_BITS(PT_BITS), .LW(LW)) bus ();
  acorn_phase_ctrl #(.AD_BITS(AD_BITS), .PT_BITS(PT_BITS), .LW(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic busy, upd, done, m, ca, cb, ev;
    logic [LW-1:0] eidx;
    logic tv;
  } stp_t;

  typedef struct {
    logic [127:0]       key, iv;
    logic [AD_BITS-1:0] ad;
    logic [PT_BITS-1:0] pt;
    logic [LW-1:0]      adl, ptl;
    int                 exp_cyc;
  } vec_t;

  stp_t exp_q[$];
  vec_t tbl[5];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic stp_t actual();
    stp_t a;
    a.busy = bus.busy; a.upd = bus.upd_en; a.done = bus.done; a.m = bus.m_bit;
    a.ca = bus.ca; a.cb = bus.cb; a.ev = bus.enc_vld;
    a.eidx = bus.enc_vld ? bus.enc_idx : '0; a.tv = bus.tag_vld;
    return a;
  endfunction

  function automatic logic [31:0] all_outs();
    return {17'd0, bus.upd_en, bus.m_bit, bus.ca, bus.cb, bus.enc_vld,
            bus.enc_idx, bus.tag_vld, bus.busy, bus.done};
  endfunction

  // Expected step stream derived directly from the phase definitions.
  task automatic build(input vec_t v);
    stp_t s;
    int adl, ptl;
    adl = (int'(v.adl) > AD_BITS) ? AD_BITS : int'(v.adl);
    ptl = (int'(v.ptl) > PT_BITS) ? PT_BITS : int'(v.ptl);
    exp_q.delete();
    for (int i = 0; i < 1792; i++) begin
      s = '0; s.busy = 1; s.upd = 1; s.ca = 1; s.cb = 1;
      if (i < 128)       s.m = v.key[i];
      else if (i < 256)  s.m = v.iv[i-128];
      else if (i == 256) s.m = ~v.key[0];
      else               s.m = v.key[i%128];
      exp_q.push_back(s);
    end
    for (int i = 0; i < adl + 256; i++) begin
      s = '0; s.busy = 1; s.upd = 1; s.cb = 1;
      s.m  = (i < adl) ? v.ad[i] : (i == adl);
      s.ca = (i < adl + 128);
      exp_q.push_back(s);
    end
    for (int i = 0; i < ptl + 256; i++) begin
      s = '0; s.busy = 1; s.upd = 1; s.cb = 0;
      s.m  = (i < ptl) ? v.pt[i] : (i == ptl);
      s.ca = (i < ptl + 128);
      s.ev = (i < ptl);
      if (i < ptl) s.eidx = LW'(i);
      exp_q.push_back(s);
    end
    for (int i = 0; i < 768; i++) begin
      s = '0; s.busy = 1; s.upd = 1; s.ca = 1; s.cb = 1;
      s.tv = (i >= 640);
      exp_q.push_back(s);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.key_in = v.key; bus.iv_in = v.iv; bus.ad_in = v.ad; bus.pt_in = v.pt;
    bus.ad_len = v.adl; bus.pt_len = v.ptl;
  endtask

  // Full run: start, scramble inputs while busy, re-pulse start at cycle 100,
  // compare every step against the queue, then the done pulse and its timing.
  task automatic run_case(input int id, input vec_t v);
    stp_t e, a;
    build(v);
    drive(v);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.key_in = ~v.key; bus.iv_in = ~v.iv; bus.ad_in = ~v.ad; bus.pt_in = ~v.pt;
    bus.ad_len = ~v.adl; bus.pt_len = ~v.ptl;
    for (int n = 1; n < 5000; n++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        if (a !== e) begin
          n_cmp++; n_bad++;
          $display("FAIL run%0d cyc%0d step: got %h want %h", id, n, a, e);
        end else n_cmp++;
      end else begin
        chk($sformatf("run%0d done", id), {29'd0, bus.done, bus.upd_en, bus.busy}, 32'b100);
        chk($sformatf("run%0d done_cycle", id), n, v.exp_cyc);
        break;
      end
      bus.start = (n == 100);
      step();
    end
    bus.start = 1'b0;
    step();
    chk($sformatf("run%0d idle_after", id), all_outs(), 32'd0);
  endtask

  initial begin
    stp_t e;
    tbl[0] = '{key: 128'h0123456789ABCDEF0123456789ABCDEF, iv: 128'h0,
               ad: 128'hA5C3_0F1E_7788_1234_DEAD_BEEF_5A5A_9C01,
               pt: 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210,
               adl: 8'd128, ptl: 8'd128, exp_cyc: 3329};
    tbl[1] = '{key: 128'hFEDC_BA98_0000_FFFF_1111_2222_3333_4444,
               iv: 128'h8000_0000_0000_0000_0000_0000_0000_0001,
               ad: '1, pt: '1, adl: 8'd0, ptl: 8'd0, exp_cyc: 3073};
    tbl[2] = '{key: 128'h0F0F_F0F0_1234_5678_9ABC_DEF0_0000_0001,
               iv: 128'hCAFE_F00D_0000_0000_1111_1111_2222_2222,
               ad: '0, pt: 128'b10110, adl: 8'd0, ptl: 8'd5, exp_cyc: 3078};
    tbl[3] = '{key: 128'h5555_AAAA_5555_AAAA_0123_4567_89AB_CDEF,
               iv: 128'h0000_1111_2222_3333_4444_5555_6666_7777,
               ad: 128'h8421_8421_0F0F_0F0F_FFFF_0000_1248_1248,
               pt: 128'h7E7E_8181_3C3C_C3C3_0000_FFFF_9999_6666,
               adl: 8'd200, ptl: 8'd255, exp_cyc: 3329};
    tbl[4] = '{key: 128'hDEAD_BEEF_CAFE_BABE_0BAD_F00D_1234_5678,
               iv: 128'h1111_0000_EEEE_FFFF_0101_1010_ABAB_CDCD,
               ad: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               pt: 128'hFFFF_0000_FFFF_0000_AAAA_5555_AAAA_5555,
               adl: 8'd37, ptl: 8'd90, exp_cyc: 3200};

    bus.start = 1'b0;
    drive(tbl[0]);
`ifdef ACORN_PHASE_ABORT_EN
    bus.abort = 1'b0;
`endif
    step(); step();
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_outs", all_outs(), 32'd0);

    for (int i = 0; i < 5; i++) run_case(i, tbl[i]);

    // Restart ignored while busy, then reset mid-run clears everything.
    build(tbl[0]);
    drive(tbl[0]);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 2000; n++) begin
      if (n == 2000) begin
        rst = 1'b1;
        #1;
        chk("rst_midrun_outs", all_outs(), 32'd0);
        break;
      end
      e = exp_q.pop_front();
      if (actual() !== e) begin
        n_cmp++; n_bad++;
        $display("FAIL restart cyc%0d step: got %h want %h", n, actual(), e);
      end else n_cmp++;
      bus.start = (n == 100);
      step();
    end
    bus.start = 1'b0;
    step();
    chk("rst_held_outs", all_outs(), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_release_outs", all_outs(), 32'd0);
    run_case(5, tbl[1]);

`ifdef ACORN_PHASE_ABORT_EN
    // Abort at AD step 10 (global step 1802, visible at cycle 1803).
    build(tbl[0]);
    drive(tbl[0]);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 1803; n++) begin
      e = exp_q.pop_front();
      if (actual() !== e) begin
        n_cmp++; n_bad++;
        $display("FAIL abort_run cyc%0d step: got %h want %h", n, actual(), e);
      end else n_cmp++;
      if (n < 1803) step();
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_edge", {29'd0, bus.upd_en, bus.busy, bus.aborted}, 32'b001);
    step();
    chk("abort_pulse_end", {30'd0, bus.aborted, bus.upd_en}, 32'd0);
    begin
      int seen = 0;
      for (int n = 0; n < 1600; n++) begin
        if (bus.done || bus.aborted || bus.upd_en) seen++;
        step();
      end
      chk("abort_no_done", seen, 0);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_beats_start", {29'd0, bus.upd_en, bus.busy, bus.aborted}, 32'd0);
    step();
    run_case(6, tbl[2]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
